// File: rtl/ps2_rx_decoder.sv
// PS/2 device-to-host receiver: conditions the raw bus, deframes 11-bit frames, folds E0/F0 prefixes into key events.
// Latency: stop-bit strobe in cycle N -> RX_BYTE_VALID / error pulse at N+1 -> KEY_VALID at N+2.
// Backpressure: none; all outputs are single-cycle pulses with held data, and the consumer must accept every pulse.
//
// Ports:
//   CLK, RESET             system clock, asynchronous active-high reset
//   PS2_CLK_IN/DATA_IN     raw PS/2 bus levels, asynchronous to CLK
//   ENABLE                 0 holds the receiver idle while the host owns the bus
//   RX_BYTE(_VALID)        last good byte and its update pulse
//   KEY_CODE/EXTENDED/RELEASE/VALID   decoded key event and its update pulse
//   PARITY_ERROR, FRAME_ERROR         single-cycle error pulses
module ps2_rx_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 80000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    input  logic       ENABLE,
    output logic [7:0] RX_BYTE,
    output logic       RX_BYTE_VALID,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXTENDED,
    output logic       KEY_RELEASE,
    output logic       KEY_VALID,
    output logic       PARITY_ERROR,
    output logic       FRAME_ERROR
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_nxt;
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_flt, clk_flt_d;
    logic [FW-1:0] flt_cnt;
    logic          strobe;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          ok_set, perr_set, ferr_set;
    logic          ext, rel;

    // 2-FF synchronizers; reset to the bus-idle level so no false start is seen.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2_CLK_IN;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2_DATA_IN;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_flt   <= 1'b1;
            clk_flt_d <= 1'b1;
            flt_cnt   <= '0;
        end else begin
            clk_flt_d <= clk_flt;
            if (clk_s2 != clk_flt) begin
                if (flt_cnt == FLT_LAST) begin
                    clk_flt <= clk_s2;
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    assign strobe  = clk_flt_d & ~clk_flt;
    assign timeout = (state != IDLE) && (to_cnt == TO_MAX);

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; timeout wins over a coincident strobe.
    always_comb begin
        state_nxt = state;
        if (!ENABLE || timeout) begin
            state_nxt = IDLE;
        end else if (strobe) begin
            case (state)
                IDLE:    if (!dat_s2) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode: stop bit outranks parity; nothing pulses while disabled.
    always_comb begin
        ok_set   = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        if (ENABLE) begin
            if (timeout) begin
                ferr_set = 1'b1;
            end else if (strobe && state == STOP) begin
                if (!dat_s2)                  ferr_set = 1'b1;
                else if (^{shreg, par_bit})   ok_set   = 1'b1;
                else                          perr_set = 1'b1;
            end
        end
    end

    // Frame datapath and inter-strobe timeout counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            to_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (!ENABLE || state == IDLE || strobe) to_cnt <= '0;
            else                                    to_cnt <= to_cnt + 1'b1;

            if (ENABLE && strobe) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: par_bit <= dat_s2;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RX_BYTE       <= '0;
            RX_BYTE_VALID <= 1'b0;
            PARITY_ERROR  <= 1'b0;
            FRAME_ERROR   <= 1'b0;
        end else begin
            RX_BYTE_VALID <= ok_set;
            PARITY_ERROR  <= perr_set;
            FRAME_ERROR   <= ferr_set;
            if (ok_set) RX_BYTE <= shreg;
        end
    end

    // Scan-code decoder: prefixes accumulate until a real key byte consumes them.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ext          <= 1'b0;
            rel          <= 1'b0;
            KEY_CODE     <= '0;
            KEY_EXTENDED <= 1'b0;
            KEY_RELEASE  <= 1'b0;
            KEY_VALID    <= 1'b0;
        end else begin
            KEY_VALID <= 1'b0;
            if (!ENABLE || PARITY_ERROR || FRAME_ERROR) begin
                ext <= 1'b0;
                rel <= 1'b0;
            end else if (RX_BYTE_VALID) begin
                case (RX_BYTE)
                    8'hE0: ext <= 1'b1;
                    8'hF0: rel <= 1'b1;
                    8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                    default: begin
                        KEY_CODE     <= RX_BYTE;
                        KEY_EXTENDED <= ext;
                        KEY_RELEASE  <= rel;
                        KEY_VALID    <= 1'b1;
                        ext          <= 1'b0;
                        rel          <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench for ps2_rx_decoder: drives PS/2 frames bit by bit and checks pulses and decoded events.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_rx_decoder;

    localparam int FLT  = 8;
    localparam int TO   = 2000;
    localparam int HALF = 60;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       PS2_CLK_IN;
    logic       PS2_DATA_IN;
    logic       ENABLE;
    logic [7:0] RX_BYTE;
    logic       RX_BYTE_VALID;
    logic [7:0] KEY_CODE;
    logic       KEY_EXTENDED;
    logic       KEY_RELEASE;
    logic       KEY_VALID;
    logic       PARITY_ERROR;
    logic       FRAME_ERROR;

    ps2_rx_decoder #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RESET(RESET), .PS2_CLK_IN(PS2_CLK_IN), .PS2_DATA_IN(PS2_DATA_IN),
        .ENABLE(ENABLE), .RX_BYTE(RX_BYTE), .RX_BYTE_VALID(RX_BYTE_VALID),
        .KEY_CODE(KEY_CODE), .KEY_EXTENDED(KEY_EXTENDED), .KEY_RELEASE(KEY_RELEASE),
        .KEY_VALID(KEY_VALID), .PARITY_ERROR(PARITY_ERROR), .FRAME_ERROR(FRAME_ERROR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int rx_n = 0, key_n = 0, pe_n = 0, fe_n = 0, wide = 0;
    int rx_cyc = 0, key_cyc = 0, fe_cyc = 0;
    logic [7:0] rx_last = '0, key_last = '0;
    logic key_ext = 1'b0, key_rel = 1'b0;
    logic rxv_q = 1'b0, kv_q = 1'b0, pe_q = 1'b0, fe_q = 1'b0;
    int r0, k0, p0, f0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge away from register updates.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (RX_BYTE_VALID) begin rx_n++; rx_cyc = cyc; rx_last = RX_BYTE; end
            if (KEY_VALID) begin
                key_n++; key_cyc = cyc; key_last = KEY_CODE;
                key_ext = KEY_EXTENDED; key_rel = KEY_RELEASE;
            end
            if (PARITY_ERROR) pe_n++;
            if (FRAME_ERROR) begin fe_n++; fe_cyc = cyc; end
            if ((RX_BYTE_VALID && rxv_q) || (KEY_VALID && kv_q) ||
                (PARITY_ERROR && pe_q) || (FRAME_ERROR && fe_q)) wide++;
        end
        rxv_q = RX_BYTE_VALID;
        kv_q  = KEY_VALID;
        pe_q  = PARITY_ERROR;
        fe_q  = FRAME_ERROR;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic v);
        PS2_DATA_IN = v;
        idle(HALF);
        PS2_CLK_IN = 1'b0;
        fall_cyc = cyc;
        idle(HALF);
        PS2_CLK_IN = 1'b1;
    endtask

    // Sends bits [lo..hi] of the 11-bit frame {stop, parity, data, start}.
    task automatic send_part(input logic [7:0] b, input logic p, input logic s,
                             input int lo, input int hi);
        logic [10:0] fr;
        fr = {s, p, b, 1'b0};
        for (int i = lo; i <= hi; i++) send_bit(fr[i]);
        PS2_DATA_IN = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
        send_part(b, p, s, 0, 10);
        idle(300);
    endtask

    task automatic snap;
        r0 = rx_n; k0 = key_n; p0 = pe_n; f0 = fe_n;
    endtask

    initial begin
        RESET = 1'b1;
        PS2_CLK_IN = 1'b1;
        PS2_DATA_IN = 1'b1;
        ENABLE = 1'b1;
        idle(5);
        check("rst_rx_byte", RX_BYTE, 8'h00);
        check("rst_rx_vld", RX_BYTE_VALID, 1'b0);
        check("rst_key_code", KEY_CODE, 8'h00);
        check("rst_key_flags", {KEY_EXTENDED, KEY_RELEASE}, 2'b00);
        check("rst_key_vld", KEY_VALID, 1'b0);
        check("rst_errs", {PARITY_ERROR, FRAME_ERROR}, 2'b00);
        RESET = 1'b0;
        idle(20);

        // 1: plain make code 0x1C
        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t1_rx_cnt", rx_n - r0, 1);
        check("t1_rx_byte", rx_last, 8'h1C);
        check("t1_rx_hold", RX_BYTE, 8'h1C);
        check("t1_key_cnt", key_n - k0, 1);
        check("t1_key_lat", key_cyc - rx_cyc, 1);
        check("t1_key", {key_ext, key_rel, key_last}, {2'b00, 8'h1C});

        // 2: release F0 1C
        snap();
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t2_rx_cnt", rx_n - r0, 2);
        check("t2_key_cnt", key_n - k0, 1);
        check("t2_key", {key_ext, key_rel, key_last}, {2'b01, 8'h1C});

        // 3: extended release E0 F0 75, then plain 29
        snap();
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        check("t3_key_cnt", key_n - k0, 1);
        check("t3_key", {key_ext, key_rel, key_last}, {2'b11, 8'h75});
        send_frame(8'h29, 1'b0, 1'b1);
        check("t3_next_key", {key_ext, key_rel, key_last}, {2'b00, 8'h29});

        // 4: parity error, then stop error; errors drop a pending F0
        send_frame(8'hF0, 1'b1, 1'b1);
        snap();
        send_frame(8'h1C, 1'b1, 1'b1);
        check("t4_pe_cnt", pe_n - p0, 1);
        check("t4_pe_novld", {rx_n - r0, key_n - k0, fe_n - f0}, 0);
        snap();
        send_frame(8'h29, 1'b0, 1'b0);
        check("t4_fe_cnt", fe_n - f0, 1);
        check("t4_fe_only", {rx_n - r0, key_n - k0, pe_n - p0}, 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t4_flag_clr", {key_ext, key_rel, key_last}, {2'b00, 8'h1C});

        // 5: truncated frame -> timeout, then recovery
        snap();
        send_part(8'h29, 1'b0, 1'b1, 0, 4);
        idle(TO + 200);
        check("t5_fe_cnt", fe_n - f0, 1);
        check("t5_fe_lat", ((fe_cyc - fall_cyc) >= TO) && ((fe_cyc - fall_cyc) <= TO + 20), 1);
        check("t5_no_rx", rx_n - r0, 0);
        send_frame(8'h29, 1'b0, 1'b1);
        check("t5_recover", {rx_last, key_last}, {8'h29, 8'h29});

        // 6a: short low glitch with data low must not start a frame
        snap();
        PS2_DATA_IN = 1'b0;
        PS2_CLK_IN = 1'b0;
        idle(3);
        PS2_CLK_IN = 1'b1;
        PS2_DATA_IN = 1'b1;
        idle(300);
        // 6b: device response FA
        send_frame(8'hFA, 1'b1, 1'b1);
        check("t6_fa_rx", {rx_n - r0, 24'(rx_last)}, {32'd1 + 32'd0, 24'hFA} >> 0 == 0 ? 0 : {8'd1, 24'hFA});
        check("t6_fa_nokey", key_n - k0, 0);
        check("t6_fa_noerr", {pe_n - p0, fe_n - f0}, 0);
        // 6c: ENABLE dropped mid-frame; the trailing bits are all ones
        snap();
        send_part(8'hF9, 1'b1, 1'b1, 0, 3);
        ENABLE = 1'b0;
        send_part(8'hF9, 1'b1, 1'b1, 4, 5);
        ENABLE = 1'b1;
        send_part(8'hF9, 1'b1, 1'b1, 6, 10);
        idle(300);
        check("t6_en_quiet", {rx_n - r0, key_n - k0, pe_n - p0, fe_n - f0}, 0);
        send_frame(8'h29, 1'b0, 1'b1);
        check("t6_en_recover", {key_ext, key_rel, key_last}, {2'b00, 8'h29});
        // ENABLE low between frames clears a pending F0
        send_frame(8'hF0, 1'b1, 1'b1);
        ENABLE = 1'b0;
        idle(10);
        ENABLE = 1'b1;
        idle(10);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t6_en_flag_clr", {key_ext, key_rel, key_last}, {2'b00, 8'h1C});

        check("pulse_width", wide, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
